// File: rtl/mul_sequencer.sv
// Multi-cycle radix-2 shift-add multiplier for mul/mulh/mulhu.
// Holds the pipeline via stall while the 34-cycle sequence runs.
module mul_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [3:0]      aluop,
  input  logic            kill,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam logic [3:0] OP_MUL   = 4'b0101;
  localparam logic [3:0] OP_MULH  = 4'b0110;
  localparam logic [3:0] OP_MULHU = 4'b0111;

  typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_t;

  state_t              state, state_nxt;
  logic [5:0]          cnt;
  logic [2*XLEN-1:0]   acc;
  logic [2*XLEN-1:0]   mcand;
  logic [XLEN-1:0]     mplier;
  logic [3:0]          op;
  logic                neg;

  logic                op_valid;
  logic                is_mulh;
  logic                accept;
  logic [XLEN-1:0]     a_in;
  logic [XLEN-1:0]     b_in;
  logic [2*XLEN-1:0]   prod_fix;
  logic [XLEN-1:0]     sel;

  assign op_valid = (aluop == OP_MUL) || (aluop == OP_MULH) || (aluop == OP_MULHU);
  assign is_mulh  = (aluop == OP_MULH);
  assign accept   = (state == IDLE) && start && op_valid && !kill;

  // mulh works on magnitudes; the sign is reapplied once in SIGN.
  assign a_in = (is_mulh && rs1[XLEN-1]) ? (~rs1 + 1'b1) : rs1;
  assign b_in = (is_mulh && rs2[XLEN-1]) ? (~rs2 + 1'b1) : rs2;

  assign prod_fix = neg ? (~acc + 1'b1) : acc;
  assign sel      = (op == OP_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = CALC;
      CALC: if (cnt == 6'(XLEN - 1)) state_nxt = SIGN;
      SIGN: state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (kill) state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      op     <= '0;
      neg    <= 1'b0;
      result <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (accept) begin
            mcand  <= {{XLEN{1'b0}}, a_in};
            mplier <= b_in;
            op     <= aluop;
            neg    <= is_mulh & (rs1[XLEN-1] ^ rs2[XLEN-1]);
            acc    <= '0;
            cnt    <= '0;
          end
        end
        CALC: begin
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 6'd1;
        end
        SIGN: begin
          acc <= prod_fix;
          // A flush arriving in SIGN leaves the previous result visible.
          if (!kill) result <= sel;
        end
        default: ;
      endcase
    end
  end

  assign stall = accept || (state == CALC) || (state == SIGN);
  assign busy  = (state != IDLE);
  assign done  = (state == DONE) && !kill;

endmodule

// File: tb/tb_mul_sequencer.sv
// Directed bench for mul_sequencer: vector table plus kill/reset/busy-start sequences.
module tb_mul_sequencer;

  localparam logic [3:0] OP_MUL   = 4'b0101;
  localparam logic [3:0] OP_MULH  = 4'b0110;
  localparam logic [3:0] OP_MULHU = 4'b0111;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  aluop;
  logic        kill;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        stall;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[10];

  mul_sequencer #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .aluop(aluop), .kill(kill),
    .rs1(rs1), .rs2(rs2), .stall(stall), .busy(busy), .done(done), .result(result)
  );

  // clock / reset
  always #5 clk = ~clk;

  always @(negedge clk) if (done) done_cnt <= done_cnt + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Issues one op and follows it to done; poke_at > 0 re-asserts start while busy.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int poke_at);
    int cycles;
    int stall_cnt;
    int d0;
    logic [31:0] e;
    exp_q.push_back(exp);
    d0 = done_cnt;
    @(negedge clk);
    start = 1'b1; aluop = op; rs1 = a; rs2 = b;
    #1 check("stall_on_accept", {31'b0, stall}, 32'd1);
    @(posedge clk); #1;
    start = 1'b0;
    rs1 = $urandom; rs2 = $urandom;
    cycles = 1;
    stall_cnt = 0;
    while (!done && cycles < 100) begin
      if (stall) stall_cnt++;
      if (cycles == poke_at) begin
        start = 1'b1; aluop = OP_MUL; rs1 = 32'd9; rs2 = 32'd9;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      cycles++;
    end
    start = 1'b0;
    e = exp_q.pop_front();
    check("latency", cycles, 32'd34);
    check("stall_cycles", stall_cnt, 32'd33);
    check("stall_in_done", {31'b0, stall}, 32'd0);
    check("busy_in_done", {31'b0, busy}, 32'd1);
    check("result", result, e);
    @(posedge clk); #1;
    check("done_one_pulse", {31'b0, done}, 32'd0);
    check("idle_after_done", {31'b0, busy}, 32'd0);
    check("result_held", result, e);
    check("done_count", done_cnt - d0, 32'd1);
  endtask

  initial begin
    vecs[0] = '{OP_MUL,   32'd7,        32'd6,        32'h0000002A};
    vecs[1] = '{OP_MUL,   32'hFFFFFFFD, 32'd5,        32'hFFFFFFF1};
    vecs[2] = '{OP_MULH,  32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF};
    vecs[3] = '{OP_MULH,  32'h80000000, 32'h80000000, 32'h40000000};
    vecs[4] = '{OP_MULH,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000};
    vecs[5] = '{OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
    vecs[6] = '{OP_MULHU, 32'h00010000, 32'h00010000, 32'h00000001};
    vecs[7] = '{OP_MUL,   32'd3,        32'd4,        32'h0000000C};
    vecs[8] = '{OP_MULH,  32'h80000000, 32'd1,        32'hFFFFFFFF};
    vecs[9] = '{OP_MUL,   32'h80000000, 32'd2,        32'h00000000};

    rst = 1'b1; start = 1'b0; aluop = 4'b0; kill = 1'b0; rs1 = '0; rs2 = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    check("rst_stall", {31'b0, stall}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_result", result, 32'd0);

    for (int i = 0; i < 10; i++)
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, 0);

    // start while busy must be ignored
    run_op(OP_MUL, 32'd5, 32'd5, 32'h00000019, 6);

    // invalid aluop
    begin
      int d0;
      d0 = done_cnt;
      @(negedge clk);
      start = 1'b1; aluop = 4'b0011; rs1 = 32'd7; rs2 = 32'd6;
      #1 check("inv_stall", {31'b0, stall}, 32'd0);
      @(posedge clk); #1;
      start = 1'b0;
      check("inv_busy", {31'b0, busy}, 32'd0);
      repeat (40) @(posedge clk);
      #1 check("inv_no_done", done_cnt - d0, 32'd0);
      check("inv_result", result, 32'h00000019);
    end

    // kill in CALC cycle 10, then immediate restart
    run_op(OP_MUL, 32'd7, 32'd6, 32'h0000002A, 0);
    begin
      int d0;
      d0 = done_cnt;
      @(negedge clk);
      start = 1'b1; aluop = OP_MULHU; rs1 = 32'hFFFFFFFF; rs2 = 32'hFFFFFFFF;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (9) @(posedge clk);
      @(negedge clk);
      kill = 1'b1;
      @(posedge clk); #1;
      kill = 1'b0;
      check("kill_busy", {31'b0, busy}, 32'd0);
      check("kill_stall", {31'b0, stall}, 32'd0);
      check("kill_done", {31'b0, done}, 32'd0);
      check("kill_result", result, 32'h0000002A);
      run_op(OP_MUL, 32'd3, 32'd4, 32'h0000000C, 0);
      check("kill_no_extra_done", done_cnt - d0, 32'd1);
    end

    // rst in CALC cycle 20
    begin
      int d0;
      d0 = done_cnt;
      @(negedge clk);
      start = 1'b1; aluop = OP_MUL; rs1 = 32'd100; rs2 = 32'd100;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (19) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("rst_mid_stall", {31'b0, stall}, 32'd0);
      check("rst_mid_busy", {31'b0, busy}, 32'd0);
      check("rst_mid_done", {31'b0, done}, 32'd0);
      check("rst_mid_result", result, 32'd0);
      repeat (20) @(posedge clk);
      #1 check("rst_mid_no_done", done_cnt - d0, 32'd0);
      run_op(OP_MULH, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
